// File: rtl/display_timing_pkg.sv
// Raster timing descriptors and the derivation of per-axis counter constants.
// Pure declarations; no logic, latency or flow control.
package display_timing_pkg;

    typedef struct packed {
        logic [15:0] h_res;
        logic [15:0] h_fp;
        logic [15:0] h_sync;
        logic [15:0] h_bp;
        logic [15:0] v_res;
        logic [15:0] v_fp;
        logic [15:0] v_sync;
        logic [15:0] v_bp;
        logic        h_pol;
        logic        v_pol;
    } timing_t;

    localparam timing_t TIMING_480P = '{
        h_res: 16'd640,  h_fp: 16'd16,  h_sync: 16'd96, h_bp: 16'd48,
        v_res: 16'd480,  v_fp: 16'd10,  v_sync: 16'd2,  v_bp: 16'd33,
        h_pol: 1'b0,     v_pol: 1'b0
    };

    localparam timing_t TIMING_720P = '{
        h_res: 16'd1280, h_fp: 16'd110, h_sync: 16'd40, h_bp: 16'd220,
        v_res: 16'd720,  v_fp: 16'd5,   v_sync: 16'd5,  v_bp: 16'd20,
        h_pol: 1'b1,     v_pol: 1'b1
    };

    // Blanking sits at negative coordinates so the active area starts at 0.
    typedef struct packed {
        int sta;
        int s_sta;
        int s_end;
        int a_end;
    } axis_t;

    function automatic axis_t axis_consts(input int res, input int fp,
                                          input int sync, input int bp);
        axis_t a;
        a.sta   = -(fp + sync + bp);
        a.s_sta = a.sta + fp;
        a.s_end = a.s_sta + sync;
        a.a_end = res - 1;
        return a;
    endfunction

endpackage

// File: rtl/display_axis_cnt.sv
// One raster axis: signed wrapping position counter plus flags decoded from its next value.
// Latency: cnt is registered; flags are combinational on the next value so the parent can register them in step with cnt.
// Backpressure: none; advances whenever en is high.
module display_axis_cnt #(
    parameter int W     = 16,
    parameter int STA   = -160,
    parameter int S_STA = -144,
    parameter int S_END = -48,
    parameter int A_END = 639
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    output logic signed [W-1:0] cnt,
    output logic                sync,
    output logic                act,
    output logic                start
);

    localparam logic signed [W-1:0] STA_W   = W'(STA);
    localparam logic signed [W-1:0] S_STA_W = W'(S_STA);
    localparam logic signed [W-1:0] S_END_W = W'(S_END);
    localparam logic signed [W-1:0] A_END_W = W'(A_END);
    localparam logic signed [W-1:0] ONE     = W'(1);
    localparam logic signed [W-1:0] ZERO    = '0;

    logic signed [W-1:0] nxt;

    always_comb begin
        nxt = cnt;
        if (en) begin
            nxt = (cnt == A_END_W) ? STA_W : cnt + ONE;
        end
    end

    // All operands are signed: blanking positions must compare below zero.
    assign sync  = (nxt >= S_STA_W) && (nxt < S_END_W);
    assign act   = (nxt >= ZERO);
    assign start = (nxt == STA_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= STA_W;
        end else begin
            cnt <= nxt;
        end
    end

endmodule

// File: rtl/display_timings_480p.sv
// 640x480 60 Hz raster timing generator: signed coordinates, syncs, data enable, line/frame strobes.
// Latency: single register stage; every flag is aligned with the sx/sy it describes.
// Backpressure: none; outputs are free-running in the clk_pix domain.
module display_timings_480p
    import display_timing_pkg::*;
#(
    parameter int CORDW  = 16,
    parameter int FRAMEW = 16,
    parameter int H_RES  = int'(TIMING_480P.h_res),
    parameter int H_FP   = int'(TIMING_480P.h_fp),
    parameter int H_SYNC = int'(TIMING_480P.h_sync),
    parameter int H_BP   = int'(TIMING_480P.h_bp),
    parameter int V_RES  = int'(TIMING_480P.v_res),
    parameter int V_FP   = int'(TIMING_480P.v_fp),
    parameter int V_SYNC = int'(TIMING_480P.v_sync),
    parameter int V_BP   = int'(TIMING_480P.v_bp),
    parameter int H_POL  = int'(TIMING_480P.h_pol),
    parameter int V_POL  = int'(TIMING_480P.v_pol)
) (
    input  logic                    clk_pix,
    input  logic                    rst_pix,
    output logic signed [CORDW-1:0] sx,
    output logic signed [CORDW-1:0] sy,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    de,
    output logic                    line,
    output logic                    frame,
    output logic [FRAMEW-1:0]       frame_cnt
);

    localparam axis_t HC = axis_consts(H_RES, H_FP, H_SYNC, H_BP);
    localparam axis_t VC = axis_consts(V_RES, V_FP, V_SYNC, V_BP);
    localparam logic signed [CORDW-1:0] HA_END = CORDW'(HC.a_end);
    localparam logic HP = 1'(H_POL);
    localparam logic VP = 1'(V_POL);

    logic h_wrap;
    logic h_sync, h_act, h_start;
    logic v_sync, v_act, v_start;

    assign h_wrap = (sx == HA_END);

    display_axis_cnt #(
        .W(CORDW), .STA(HC.sta), .S_STA(HC.s_sta), .S_END(HC.s_end), .A_END(HC.a_end)
    ) u_h_cnt (
        .clk(clk_pix), .rst(rst_pix), .en(1'b1),
        .cnt(sx), .sync(h_sync), .act(h_act), .start(h_start)
    );

    display_axis_cnt #(
        .W(CORDW), .STA(VC.sta), .S_STA(VC.s_sta), .S_END(VC.s_end), .A_END(VC.a_end)
    ) u_v_cnt (
        .clk(clk_pix), .rst(rst_pix), .en(h_wrap),
        .cnt(sy), .sync(v_sync), .act(v_act), .start(v_start)
    );

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            hsync     <= ~HP;
            vsync     <= ~VP;
            de        <= 1'b0;
            line      <= 1'b0;
            frame     <= 1'b0;
            frame_cnt <= '0;
        end else begin
            hsync <= h_sync ~^ HP;
            vsync <= v_sync ~^ VP;
            de    <= h_act && v_act;
            line  <= h_start;
            frame <= h_start && v_start;
            // Counted on the strobe edge so the new count appears with frame.
            if (h_start && v_start) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_display_timings_480p.sv
// Directed bench: a default 480p instance for reset and line timing, and a shrunken-timing
// instance (15x9 raster, 2-bit frame counter) for frame, wrap, vsync and mid-frame reset behaviour.
module tb_display_timings_480p;

    logic clk_pix = 1'b0;
    logic rst_pix;
    always #5 clk_pix = ~clk_pix;

    logic signed [15:0] b_sx, b_sy, s_sx, s_sy;
    logic b_hs, b_vs, b_de, b_line, b_frame;
    logic s_hs, s_vs, s_de, s_line, s_frame;
    logic [15:0] b_fc;
    logic [1:0]  s_fc;

    int k;
    int n_chk;
    int n_fail;

    display_timings_480p u_big (
        .clk_pix(clk_pix), .rst_pix(rst_pix), .sx(b_sx), .sy(b_sy),
        .hsync(b_hs), .vsync(b_vs), .de(b_de), .line(b_line), .frame(b_frame),
        .frame_cnt(b_fc)
    );

    // Small raster: H_STA=-7 HS=[-5,-2) HA_END=7 (15/line); V_STA=-5 VS=[-4,-2) VA_END=3 (9 lines); 135/frame.
    display_timings_480p #(
        .FRAMEW(2), .H_RES(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_RES(4), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) u_small (
        .clk_pix(clk_pix), .rst_pix(rst_pix), .sx(s_sx), .sy(s_sy),
        .hsync(s_hs), .vsync(s_vs), .de(s_de), .line(s_line), .frame(s_frame),
        .frame_cnt(s_fc)
    );

    typedef struct packed {
        int         sx;
        int         sy;
        logic       hs;
        logic       vs;
        logic       de;
        logic       line;
        logic       frame;
        logic [1:0] fc;
    } exp_t;

    // Expected small-raster outputs kk cycles after reset release (kk >= 1).
    function automatic exp_t small_exp(input int kk);
        exp_t e;
        e.sx    = -7 + (kk % 15);
        e.sy    = -5 + ((kk / 15) % 9);
        e.hs    = !(e.sx >= -5 && e.sx < -2);
        e.vs    = !(e.sy >= -4 && e.sy < -2);
        e.de    = (e.sx >= 0) && (e.sy >= 0);
        e.line  = (e.sx == -7);
        e.frame = e.line && (e.sy == -5);
        e.fc    = 2'((kk / 135) % 4);
        return e;
    endfunction

    task automatic tick();
        @(negedge clk_pix);
        k++;
    endtask

    task automatic test_reset();
        rst_pix = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_pix);
            n_chk++;
            if (int'(b_sx) !== -160 || int'(b_sy) !== -45 || b_hs !== 1'b1 || b_vs !== 1'b1 ||
                b_de !== 1'b0 || b_line !== 1'b0 || b_frame !== 1'b0 || b_fc !== 16'd0) begin
                n_fail++;
                $display("FAIL reset_big cyc %0d: got sx=%0d sy=%0d hs=%b vs=%b de=%b ln=%b fr=%b fc=%0d, want -160 -45 1 1 0 0 0 0",
                         i, b_sx, b_sy, b_hs, b_vs, b_de, b_line, b_frame, b_fc);
            end
            n_chk++;
            if (int'(s_sx) !== -7 || int'(s_sy) !== -5 || s_hs !== 1'b1 || s_vs !== 1'b1 ||
                s_de !== 1'b0 || s_line !== 1'b0 || s_frame !== 1'b0 || s_fc !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_small cyc %0d: got sx=%0d sy=%0d hs=%b vs=%b de=%b ln=%b fr=%b fc=%0d, want -7 -5 1 1 0 0 0 0",
                         i, s_sx, s_sy, s_hs, s_vs, s_de, s_line, s_frame, s_fc);
            end
        end
    endtask

    task automatic test_release();
        rst_pix = 1'b0;
        k = 0;
        tick();
        n_chk++;
        if (int'(b_sx) !== -159 || int'(b_sy) !== -45 || b_hs !== 1'b1 || b_line !== 1'b0 || b_frame !== 1'b0) begin
            n_fail++;
            $display("FAIL first_edge_big: got sx=%0d sy=%0d hs=%b ln=%b fr=%b, want -159 -45 1 0 0",
                     b_sx, b_sy, b_hs, b_line, b_frame);
        end
        n_chk++;
        if (int'(s_sx) !== -6 || int'(s_sy) !== -5 || s_line !== 1'b0 || s_frame !== 1'b0) begin
            n_fail++;
            $display("FAIL first_edge_small: got sx=%0d sy=%0d ln=%b fr=%b, want -6 -5 0 0",
                     s_sx, s_sy, s_line, s_frame);
        end
    endtask

    task automatic test_small_frames();
        int fc_seq [5] = '{1, 2, 3, 0, 1};
        int seen [$];
        int hs_low = 0, de_hi = 0, vs_low = 0;
        exp_t e;
        while (k < 675) begin
            tick();
            e = small_exp(k);
            n_chk++;
            if (int'(s_sx) !== e.sx || int'(s_sy) !== e.sy || s_hs !== e.hs || s_vs !== e.vs ||
                s_de !== e.de || s_line !== e.line || s_frame !== e.frame || s_fc !== e.fc) begin
                n_fail++;
                $display("FAIL small_model k=%0d: got %0d %0d hs%b vs%b de%b ln%b fr%b fc%0d, want %0d %0d hs%b vs%b de%b ln%b fr%b fc%0d",
                         k, s_sx, s_sy, s_hs, s_vs, s_de, s_line, s_frame, s_fc,
                         e.sx, e.sy, e.hs, e.vs, e.de, e.line, e.frame, e.fc);
            end
            if (!s_hs) hs_low++;
            if (!s_vs) vs_low++;
            if (s_de) de_hi++;
            if (s_frame) seen.push_back(int'(s_fc));
        end
        n_chk++;
        if (hs_low !== 135 || de_hi !== 160 || vs_low !== 150) begin
            n_fail++;
            $display("FAIL small_counts: got hs_low=%0d de=%0d vs_low=%0d, want 135 160 150", hs_low, de_hi, vs_low);
        end
        n_chk++;
        if (seen.size() !== 5) begin
            n_fail++;
            $display("FAIL frame_strobes: got %0d strobes, want 5", seen.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_chk++;
                if (seen[i] !== fc_seq[i]) begin
                    n_fail++;
                    $display("FAIL frame_cnt_seq[%0d]: got %0d, want %0d", i, seen[i], fc_seq[i]);
                end
            end
        end
    endtask

    task automatic test_wrap_boundary();
        int guard = 0;
        logic [1:0] fc_before;
        while (!(int'(s_sx) == 7 && int'(s_sy) == 3) && guard < 140) begin
            tick();
            guard++;
        end
        n_chk++;
        if (guard >= 140) begin
            n_fail++;
            $display("FAIL wrap_reach: got no sx=7 sy=3 in 140 cycles, want it reached");
        end else begin
            n_chk++;
            if (s_de !== 1'b1 || s_frame !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap_last_pixel: got de=%b fr=%b, want 1 0", s_de, s_frame);
            end
            fc_before = s_fc;
            tick();
            n_chk++;
            if (int'(s_sx) !== -7 || int'(s_sy) !== -5 || s_line !== 1'b1 || s_frame !== 1'b1 ||
                s_de !== 1'b0 || s_fc !== 2'(fc_before + 2'd1)) begin
                n_fail++;
                $display("FAIL wrap_next: got sx=%0d sy=%0d ln=%b fr=%b de=%b fc=%0d, want -7 -5 1 1 0 %0d",
                         s_sx, s_sy, s_line, s_frame, s_de, s_fc, 2'(fc_before + 2'd1));
            end
        end
    endtask

    task automatic test_vsync();
        int vs_low = 0;
        int fall_sx = 999, fall_sy = 999;
        logic prev = s_vs;
        for (int i = 0; i < 135; i++) begin
            tick();
            if (!s_vs) vs_low++;
            if (prev && !s_vs && fall_sx == 999) begin
                fall_sx = int'(s_sx);
                fall_sy = int'(s_sy);
            end
            prev = s_vs;
        end
        n_chk++;
        if (vs_low !== 30) begin
            n_fail++;
            $display("FAIL vsync_width: got %0d low cycles, want 30", vs_low);
        end
        n_chk++;
        if (fall_sx !== -7 || fall_sy !== -4) begin
            n_fail++;
            $display("FAIL vsync_edge: got fall at sx=%0d sy=%0d, want -7 -4", fall_sx, fall_sy);
        end
    endtask

    task automatic test_big_line();
        int hs_low = 0, lines = 0;
        int esx, esy;
        logic ehs, eln;
        while (k < 2400) begin
            tick();
            esx = -160 + (k % 800);
            esy = -45 + (k / 800);
            ehs = !(esx >= -144 && esx < -48);
            eln = (esx == -160);
            n_chk++;
            if (int'(b_sx) !== esx || int'(b_sy) !== esy || b_hs !== ehs || b_vs !== 1'b1 ||
                b_de !== 1'b0 || b_line !== eln || b_frame !== 1'b0 || b_fc !== 16'd0) begin
                n_fail++;
                $display("FAIL big_model k=%0d: got %0d %0d hs%b vs%b de%b ln%b fr%b fc%0d, want %0d %0d hs%b vs1 de0 ln%b fr0 fc0",
                         k, b_sx, b_sy, b_hs, b_vs, b_de, b_line, b_frame, b_fc, esx, esy, ehs, eln);
            end
            if (k > 1600 && !b_hs) hs_low++;
            if (k > 1600 && b_line) lines++;
        end
        n_chk++;
        if (hs_low !== 96 || lines !== 1) begin
            n_fail++;
            $display("FAIL big_line_counts: got hs_low=%0d lines=%0d, want 96 1", hs_low, lines);
        end
    endtask

    task automatic test_mid_reset();
        int guard = 0;
        int strobes = 0;
        exp_t e;
        while (!(s_fc == 2'd3 && int'(s_sx) == 2 && int'(s_sy) == 1) && guard < 700) begin
            tick();
            guard++;
        end
        n_chk++;
        if (guard >= 700) begin
            n_fail++;
            $display("FAIL midreset_reach: got no fc=3 sx=2 sy=1 in 700 cycles, want it reached");
            return;
        end
        rst_pix = 1'b1;
        tick();
        rst_pix = 1'b0;
        n_chk++;
        if (int'(s_sx) !== -7 || int'(s_sy) !== -5 || s_hs !== 1'b1 || s_vs !== 1'b1 || s_de !== 1'b0 ||
            s_line !== 1'b0 || s_frame !== 1'b0 || s_fc !== 2'd0) begin
            n_fail++;
            $display("FAIL midreset_small: got sx=%0d sy=%0d hs=%b vs=%b de=%b ln=%b fr=%b fc=%0d, want -7 -5 1 1 0 0 0 0",
                     s_sx, s_sy, s_hs, s_vs, s_de, s_line, s_frame, s_fc);
        end
        n_chk++;
        if (int'(b_sx) !== -160 || int'(b_sy) !== -45 || b_fc !== 16'd0 || b_frame !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_big: got sx=%0d sy=%0d fc=%0d fr=%b, want -160 -45 0 0", b_sx, b_sy, b_fc, b_frame);
        end
        k = 0;
        while (k < 135) begin
            tick();
            e = small_exp(k);
            if (s_frame) strobes++;
            n_chk++;
            if (int'(s_sx) !== e.sx || int'(s_sy) !== e.sy || s_frame !== e.frame || s_fc !== e.fc) begin
                n_fail++;
                $display("FAIL midreset_model k=%0d: got %0d %0d fr%b fc%0d, want %0d %0d fr%b fc%0d",
                         k, s_sx, s_sy, s_frame, s_fc, e.sx, e.sy, e.frame, e.fc);
            end
        end
        n_chk++;
        if (strobes !== 1 || s_frame !== 1'b1 || s_fc !== 2'd1) begin
            n_fail++;
            $display("FAIL midreset_first_frame: got strobes=%0d fr=%b fc=%0d, want 1 1 1", strobes, s_frame, s_fc);
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        k      = 0;
        rst_pix = 1'b1;
        test_reset();
        test_release();
        test_small_frames();
        test_wrap_boundary();
        test_vsync();
        test_big_line();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
